// File: rtl/counter_bank_drain.sv
// Bank of event counters with a single-cycle increment port and a drain engine
// that streams every entry out over valid/ready, clearing each entry as it is accepted.
module counter_bank_drain #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          io_inc_valid,
    input  logic [AW-1:0] io_inc_addr,
    input  logic          io_start,
    output logic          io_busy,
    output logic          io_out_valid,
    input  logic          io_out_ready,
    output logic [AW-1:0] io_out_addr,
    output logic [DW-1:0] io_out_data,
    output logic          io_done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          handshake;

    assign handshake = valid_q && io_out_ready;

    // NOTE: every always_comb output is given its current value first, so no path can infer a latch.
    always_comb begin
        mem_d = mem_q;
        if (handshake) begin
            mem_d[idx_q] = '0;
        end
        // Applied after the clear: a same-cycle increment of the drained entry leaves it at 1.
        if (io_inc_valid) begin
            mem_d[io_inc_addr] = mem_d[io_inc_addr] + DW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (io_start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (handshake) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == SCAN);
        done_d  = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the counters are flops, not a RAM, because reset must clear every entry at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign io_busy      = busy_q;
    assign io_out_valid = valid_q;
    assign io_done      = done_q;
    assign io_out_addr  = valid_q ? idx_q : '0;
    assign io_out_data  = valid_q ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_counter_bank_drain.sv
// Randomized bench for counter_bank_drain: a behavioural counter model is compared every cycle,
// with directed drains pinning latency, collisions, abort and wrap-around.
module tb_counter_bank_drain;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_inc_valid;
    logic [AW-1:0] io_inc_addr;
    logic          io_start;
    logic          io_busy;
    logic          io_out_valid;
    logic          io_out_ready;
    logic [AW-1:0] io_out_addr;
    logic [DW-1:0] io_out_data;
    logic          io_done;

    // Narrow instance used to reach the all-ones wrap in a handful of increments.
    logic          w_rst;
    logic          w_inc_valid;
    logic [AW-1:0] w_inc_addr;
    logic          w_start;
    logic          w_busy;
    logic          w_out_valid;
    logic          w_ready;
    logic [AW-1:0] w_out_addr;
    logic [3:0]    w_out_data;
    logic          w_done;

    always #5 clk = ~clk;

    counter_bank_drain #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_inc_valid (io_inc_valid),
        .io_inc_addr  (io_inc_addr),
        .io_start     (io_start),
        .io_busy      (io_busy),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_addr  (io_out_addr),
        .io_out_data  (io_out_data),
        .io_done      (io_done)
    );

    counter_bank_drain #(.DEPTH(DEPTH), .AW(AW), .DW(4)) wdut (
        .clk          (clk),
        .reset        (w_rst),
        .io_inc_valid (w_inc_valid),
        .io_inc_addr  (w_inc_addr),
        .io_start     (w_start),
        .io_busy      (w_busy),
        .io_out_valid (w_out_valid),
        .io_out_ready (w_ready),
        .io_out_addr  (w_out_addr),
        .io_out_data  (w_out_data),
        .io_done      (w_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: counts per entry, drain phase (0 idle, 1 scanning, 2 done pulse) and scan position.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_phase;
    int            m_idx;

    int            n_beats;
    int            done_cnt;
    int            done_off;
    int            start_cyc;
    logic [AW-1:0] b_addr [DEPTH];
    logic [DW-1:0] b_data [DEPTH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
        end
        m_phase = 0;
        m_idx   = 0;
    endtask

    // Called at a falling edge: drive inputs, compare outputs, advance the model, step one cycle.
    task automatic cycle(input logic st, input logic iv, input logic [AW-1:0] ia, input logic rdy);
        logic          hs;
        logic          exp_valid;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        io_start     = st;
        io_inc_valid = iv;
        io_inc_addr  = ia;
        io_out_ready = rdy;
        #1;
        exp_valid = (m_phase == 1);
        exp_addr  = exp_valid ? AW'(m_idx) : '0;
        exp_data  = exp_valid ? m_mem[m_idx] : '0;
        check("busy",  64'(io_busy),      64'(m_phase != 0));
        check("valid", 64'(io_out_valid), 64'(exp_valid));
        check("done",  64'(io_done),      64'(m_phase == 2));
        check("addr",  64'(io_out_addr),  64'(exp_addr));
        check("data",  64'(io_out_data),  64'(exp_data));

        hs = exp_valid && rdy;
        if (hs && n_beats < DEPTH) begin
            b_addr[n_beats] = io_out_addr;
            b_data[n_beats] = io_out_data;
        end
        if (hs) n_beats++;
        if (io_done) begin
            done_cnt++;
            done_off = cyc - start_cyc;
        end

        if (reset) begin
            model_clear();
        end else begin
            if (hs) m_mem[m_idx] = '0;
            if (iv) m_mem[ia] = m_mem[ia] + 1;
            case (m_phase)
                0: if (st) begin
                    m_phase = 1;
                    m_idx   = 0;
                end
                1: if (hs) begin
                    if (m_idx == DEPTH - 1) m_phase = 2;
                    else m_idx++;
                end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // rdy_mode: 0 always ready, 1 toggling starting with ready on the first beat, 2 random.
    task automatic drain(input int rdy_mode, input int collide, input bit rand_inc,
                         input bit mid_start, input int abort_at, input int tail);
        logic          st;
        logic          rdy;
        logic          iv;
        logic [AW-1:0] ia;
        n_beats   = 0;
        done_cnt  = 0;
        done_off  = -1;
        start_cyc = cyc;
        for (int k = 0; k < 80; k++) begin
            st  = (k == 0) || (mid_start && k == 3);
            rdy = (rdy_mode == 0) ? 1'b1 :
                  (rdy_mode == 1) ? ((k % 2) == 1) : 1'($urandom_range(0, 1));
            iv  = 1'b0;
            ia  = '0;
            if (collide >= 0 && m_phase == 1 && m_idx == collide && rdy) begin
                iv = 1'b1;
                ia = AW'(collide);
            end else if (rand_inc) begin
                iv = 1'($urandom_range(0, 1));
                ia = AW'($urandom_range(0, DEPTH - 1));
            end
            if (abort_at >= 0 && m_phase == 1 && m_idx == abort_at) begin
                reset = 1'b1;
                model_clear();
                #1;
                check("abort_busy",  64'(io_busy),      64'(0));
                check("abort_valid", 64'(io_out_valid), 64'(0));
                cycle(1'b0, 1'b0, '0, 1'b0);
                cycle(1'b0, 1'b0, '0, 1'b0);
                reset = 1'b0;
                return;
            end
            cycle(st, iv, ia, rdy);
            if (done_cnt > 0 && m_phase == 0) break;
        end
        check("drain_done_count", 64'(done_cnt), 64'(1));
        for (int t = 0; t < tail; t++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
        end
    endtask

    task automatic w_drain(output logic [3:0] d5, output int wdone);
        d5      = 'x;
        wdone   = 0;
        w_start = 1'b1;
        cycle(1'b0, 1'b0, '0, 1'b0);
        w_start = 1'b0;
        for (int k = 0; k < 30 && wdone == 0; k++) begin
            if (w_out_valid && w_out_addr == AW'(5)) d5 = w_out_data;
            if (w_done) wdone = 1;
            cycle(1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    initial begin
        logic [3:0]    wd;
        int            wdn;
        logic [DW-1:0] sum;
        int            idle_wait;

        reset        = 1'b1;
        io_inc_valid = 1'b0;
        io_inc_addr  = '0;
        io_start     = 1'b0;
        io_out_ready = 1'b0;
        w_rst        = 1'b1;
        w_inc_valid  = 1'b0;
        w_inc_addr   = '0;
        w_start      = 1'b0;
        w_ready      = 1'b1;
        n_beats      = 0;
        done_cnt     = 0;
        done_off     = -1;
        start_cyc    = 0;
        model_clear();

        @(negedge clk);
        #1;
        check("rst_busy",  64'(io_busy),      64'(0));
        check("rst_valid", 64'(io_out_valid), 64'(0));
        check("rst_done",  64'(io_done),      64'(0));
        check("rst_data",  64'(io_out_data),  64'(0));
        @(negedge clk);
        cycle(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b0;
        w_rst = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b0);

        // Five hits on entry 3, one on entry 7, then a full-rate drain.
        repeat (5) cycle(1'b0, 1'b1, AW'(3), 1'b0);
        cycle(1'b0, 1'b1, AW'(7), 1'b0);
        drain(0, -1, 1'b0, 1'b0, -1, 0);
        check("t1_beats",    64'(n_beats),   64'(8));
        check("t1_b0_data",  64'(b_data[0]), 64'(0));
        check("t1_b3_addr",  64'(b_addr[3]), 64'(3));
        check("t1_b3_data",  64'(b_data[3]), 64'(5));
        check("t1_b7_addr",  64'(b_addr[7]), 64'(7));
        check("t1_b7_data",  64'(b_data[7]), 64'(1));
        check("t1_done_lat", 64'(done_off),  64'(9));

        // Ready toggling: entries are zero after the first drain, beats stay in order.
        drain(1, -1, 1'b0, 1'b0, -1, 0);
        check("t2_beats",    64'(n_beats),  64'(8));
        check("t2_done_lat", 64'(done_off), 64'(16));
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_addr", 64'(b_addr[i]), 64'(i));
            check("t2_zero", 64'(b_data[i]), 64'(0));
        end

        // Increment entry 2 in the same cycle as its handshake.
        repeat (4) cycle(1'b0, 1'b1, AW'(2), 1'b0);
        drain(0, 2, 1'b0, 1'b0, -1, 0);
        check("t3_beat_data", 64'(b_data[2]), 64'(4));
        drain(0, -1, 1'b0, 1'b0, -1, 0);
        check("t3_after",     64'(b_data[2]), 64'(1));
        check("t3_neighbour", 64'(b_data[1]), 64'(0));

        // A start pulse mid-scan must not restart or queue a second drain.
        drain(0, -1, 1'b0, 1'b1, -1, 4);
        check("t5_done_once", 64'(done_cnt), 64'(1));
        check("t5_beats",     64'(n_beats),  64'(8));

        // Abort at beat 4 with counts present, then drain zeros.
        repeat (20) cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), 1'b0);
        drain(0, -1, 1'b1, 1'b0, 4, 0);
        check("t6_no_done", 64'(done_cnt), 64'(0));
        check("t6_beats",   64'(n_beats),  64'(4));
        drain(0, -1, 1'b0, 1'b0, -1, 0);
        sum = '0;
        for (int i = 0; i < DEPTH; i++) sum = sum + b_data[i];
        check("t6_zeros", 64'(sum), 64'(0));

        // Random traffic: increments, stray starts and random back-pressure.
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(5, 30)) begin
                cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)));
            end
            idle_wait = 0;
            while (m_phase != 0 && idle_wait < 40) begin
                cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), 1'b1);
                idle_wait++;
            end
            drain(2, -1, 1'b1, 1'b0, -1, 0);
        end

        // All-ones entry wraps to zero on the next increment (4-bit instance).
        w_inc_valid = 1'b1;
        w_inc_addr  = AW'(5);
        repeat (15) cycle(1'b0, 1'b0, '0, 1'b0);
        w_inc_valid = 1'b0;
        w_drain(wd, wdn);
        check("t4_all_ones", 64'(wd),  64'(4'hF));
        check("t4_done1",    64'(wdn), 64'(1));
        w_inc_valid = 1'b1;
        repeat (16) cycle(1'b0, 1'b0, '0, 1'b0);
        w_inc_valid = 1'b0;
        w_drain(wd, wdn);
        check("t4_wrap",  64'(wd),  64'(0));
        check("t4_done2", 64'(wdn), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
